// File: rtl/jt900h_dma_pkg.sv
// Purpose : shared constants and FSM encoding for the DMA request block and the uDMA.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package jt900h_dma_pkg;

    localparam int DMA_CH = 4;   // channel count, shared with the uDMA
    localparam int CH_W   = 2;   // channel index width
    localparam int VEC_W  = 5;   // start-vector width
    localparam int SRC_N  = 32;  // interrupt source count

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } dma_st_t;

endpackage

// File: rtl/jt900h_dma_prio.sv
// Purpose : fixed-priority 4-to-2 encoder, channel 0 has highest priority.
// Latency : combinational.
// Backpr. : none.
// Ports   : req  - pending channel bits
//           idx  - lowest-numbered set bit of req (0 when none set)
//           vld  - at least one bit of req is set
module jt900h_dma_prio
    import jt900h_dma_pkg::*;
(
    input  logic [DMA_CH-1:0] req,
    output logic [CH_W-1:0]   idx,
    output logic              vld
);

    always_comb begin
        vld = |req;
        idx = '0;
        // Scan downwards so the lowest set bit is the last to assign idx.
        for (int n = DMA_CH - 1; n >= 0; n--) begin
            if (req[n]) idx = CH_W'(n);
        end
    end

endmodule

// File: rtl/jt900h_dma_req.sv
// Purpose : maps interrupt strobes onto four DMA channels and requests transfers from the uDMA.
// Latency : strobe -> dma_req two cen-cycles; one idle cen-cycle between consecutive requests.
// Backpr. : request held until dma_ack; next request waits for dma_done; cen=0 freezes everything.
// Ports   : clk/rst_n/cen        - clock, async active-low reset, clock enable
//           int_stb/int_pass     - interrupt strobes in, uncaptured strobes out
//           dmav_we/sel/din/dout - start-vector register write and combinational readback
//           tc_clr               - per-channel terminal-count clear from the uDMA
//           dma_req/ch/ack/done  - request handshake with the uDMA
module jt900h_dma_req
    import jt900h_dma_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cen,
    input  logic [SRC_N-1:0]    int_stb,
    input  logic                dmav_we,
    input  logic [CH_W-1:0]     dmav_sel,
    input  logic [VEC_W-1:0]    dmav_din,
    output logic [VEC_W-1:0]    dmav_dout,
    input  logic [DMA_CH-1:0]   tc_clr,
    output logic                dma_req,
    output logic [CH_W-1:0]     dma_ch,
    input  logic                dma_ack,
    input  logic                dma_done,
    output logic [SRC_N-1:0]    int_pass
);

    logic [VEC_W-1:0]  vec [DMA_CH];
    logic [DMA_CH-1:0] pend;
    logic [DMA_CH-1:0] cap;       // strobe on this channel's vector this cycle
    logic [DMA_CH-1:0] dis;       // channel being disabled this cycle
    logic [DMA_CH-1:0] ack_clr;   // pend bit retired by the uDMA ack
    logic [SRC_N-1:0]  claimed;   // sources owned by an enabled channel
    logic [CH_W-1:0]   win_ch;
    logic              win_vld;
    dma_st_t           st;

    assign dmav_dout = vec[dmav_sel];
    assign int_pass  = int_stb & ~claimed;

    always_comb begin
        cap     = '0;
        dis     = '0;
        claimed = '0;
        for (int n = 0; n < DMA_CH; n++) begin
            cap[n] = (vec[n] != '0) && int_stb[vec[n]];
            // Either a clear or a zero write turns the channel off.
            dis[n] = tc_clr[n] || (dmav_we && dmav_sel == CH_W'(n) && dmav_din == '0);
            // Vector 0 means disabled, so source 0 is never claimed.
            if (vec[n] != '0) claimed[vec[n]] = 1'b1;
        end
    end

    always_comb begin
        ack_clr = '0;
        if (st == ST_REQ && dma_ack) ack_clr[dma_ch] = 1'b1;
    end

    jt900h_dma_prio u_prio (
        .req (pend),
        .idx (win_ch),
        .vld (win_vld)
    );

    // Vector registers and pending flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < DMA_CH; n++) vec[n] <= '0;
            pend <= '0;
        end else if (cen) begin
            for (int n = 0; n < DMA_CH; n++) begin
                if (tc_clr[n])
                    vec[n] <= '0;
                else if (dmav_we && dmav_sel == CH_W'(n))
                    vec[n] <= dmav_din;
            end
            // A fresh capture outranks the ack clear; disabling outranks both.
            pend <= ((pend & ~ack_clr) | cap) & ~dis;
        end
    end

    // Request state machine with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= ST_IDLE;
            dma_req <= 1'b0;
            dma_ch  <= '0;
        end else if (cen) begin
            case (st)
                ST_IDLE: begin
                    if (win_vld) begin
                        st      <= ST_REQ;
                        dma_req <= 1'b1;
                        dma_ch  <= win_ch;
                    end
                end
                ST_REQ: begin
                    if (dis[dma_ch]) begin
                        // Channel switched off before the uDMA took it.
                        st      <= ST_IDLE;
                        dma_req <= 1'b0;
                    end else if (dma_ack) begin
                        st      <= ST_XFER;
                        dma_req <= 1'b0;
                    end
                end
                ST_XFER: begin
                    // A running transfer is never aborted; only done ends it.
                    if (dma_done) st <= ST_IDLE;
                end
                default: begin
                    st      <= ST_IDLE;
                    dma_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
